// File: rtl/argmax_unit.sv
// Sequential argmax over a snapshot of DIM signed logits: one compare per clock,
// registered index of the largest element plus a one-cycle done pulse.
module argmax_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int DIM        = 10,
    parameter int IDXW       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic signed [DATA_WIDTH-1:0] vec [0:DIM-1],
    output logic        [IDXW-1:0]       idx,
    output logic                         done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] K_LAST = IDXW'(DIM - 1);
    localparam logic [IDXW-1:0] K_ONE  = IDXW'(1);
    localparam logic [IDXW-1:0] K_ZERO = IDXW'(0);

    state_t                       state_r;
    state_t                       state_nxt_s;
    logic signed [DATA_WIDTH-1:0] snap_r [0:DIM-1];
    logic signed [DATA_WIDTH-1:0] best_val_r;
    logic        [IDXW-1:0]       best_idx_r;
    logic        [IDXW-1:0]       k_r;
    logic        [IDXW-1:0]       idx_r;
    logic                         done_r;
    logic                         load_s;
    logic                         step_s;
    logic                         finish_s;
    logic                         greater_s;

    // Next-state decode and per-state datapath enables.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    load_s      = 1'b1;
                    state_nxt_s = (DIM == 1) ? FINISH : SCAN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                step_s = 1'b1;
                if (k_r == K_LAST) begin
                    state_nxt_s = FINISH;
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            FINISH: begin
                finish_s    = 1'b1;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Strict signed compare so that ties keep the lower index.
    always_comb begin
        greater_s = 1'b0;
        if (step_s) begin
            greater_s = (snap_r[k_r] > best_val_r);
        end else begin
            greater_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Snapshot, running best and scan counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIM; i++) begin
                snap_r[i] <= '0;
            end
            best_val_r <= '0;
            best_idx_r <= K_ZERO;
            k_r        <= K_ZERO;
        end else if (load_s) begin
            for (int i = 0; i < DIM; i++) begin
                snap_r[i] <= vec[i];
            end
            best_val_r <= vec[0];
            best_idx_r <= K_ZERO;
            k_r        <= K_ONE;
        end else if (step_s) begin
            if (greater_s) begin
                best_val_r <= snap_r[k_r];
                best_idx_r <= k_r;
            end
            // Counter parks on the last index instead of running past DIM-1.
            if (k_r != K_LAST) begin
                k_r <= k_r + K_ONE;
            end
        end
    end

    // Registered result and done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r  <= K_ZERO;
            done_r <= 1'b0;
        end else begin
            done_r <= finish_s;
            if (finish_s) begin
                idx_r <= best_idx_r;
            end
        end
    end

    assign idx  = idx_r;
    assign done = done_r;

endmodule

// File: tb/tb_argmax_unit.sv
// Directed, table-driven bench for argmax_unit (DIM=10, 16-bit elements) with
// hand-written sequences for reset, snapshot, busy, back-to-back and abort cases.
module tb_argmax_unit;

    localparam int DW  = 16;
    localparam int DIM = 10;
    localparam int IW  = 4;

    typedef logic signed [DW-1:0] vec_t [DIM];

    typedef struct {
        vec_t       v;
        logic [3:0] exp;
        string      name;
    } vec_rec_t;

    logic        clk;
    logic        reset;
    logic        start;
    vec_t        vec;
    logic [IW-1:0] idx;
    logic        done;

    int n_cmp;
    int n_fail;

    argmax_unit #(.DATA_WIDTH(DW), .DIM(DIM), .IDXW(IW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .vec   (vec),
        .idx   (idx),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present a vector and pulse start so it is sampled at the next rising edge (E0).
    task automatic launch(input vec_t a);
        @(negedge clk);
        vec   = a;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called half a cycle after E0: expect done exactly at E10, correct idx, one-cycle pulse.
    task automatic wait_check(input logic [3:0] exp, input string nm);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (!seen) begin
                @(posedge clk);
                #1;
                if (done) begin
                    seen = 1'b1;
                    cyc  = i;
                end
            end
        end
        check({nm, " latency"}, cyc, 10);
        check({nm, " idx"}, idx, exp);
        @(posedge clk);
        #1;
        check({nm, " done_pulse"}, done, 0);
    endtask

    // Start at E0, optionally a second start at E<extra>; vec switches to b after E1.
    task automatic window(input vec_t a, input vec_t b, input int extra,
                          output int nd, output int d1, output int d2,
                          output logic [3:0] i1, output logic [3:0] i2);
        nd = 0; d1 = -1; d2 = -1; i1 = 4'd0; i2 = 4'd0;
        @(negedge clk);
        vec   = a;
        start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                nd++;
                if (nd == 1) begin
                    d1 = i; i1 = idx;
                end else begin
                    d2 = i; i2 = idx;
                end
            end
            @(negedge clk);
            start = ((i + 1) == extra);
            if (i == 1) vec = b;
        end
        start = 1'b0;
    endtask

    task automatic count_quiet(input int n, input string nm);
        int nd;
        nd = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        check(nm, nd, 0);
    endtask

    vec_rec_t tbl [7];
    vec_t va, vb;
    int nd, d1, d2;
    logic [3:0] i1, i2;

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        start  = 1'b0;
        for (int i = 0; i < DIM; i++) vec[i] = 16'sd0;

        tbl[0].v = '{16'sd5, -16'sd3, 16'sd12, 16'sd7, 16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4, 16'sd11};
        tbl[0].exp = 4'd2; tbl[0].name = "basic";
        for (int i = 0; i < DIM; i++) tbl[1].v[i] = -16'sd100;
        tbl[1].v[4] = -16'sd1; tbl[1].v[8] = -16'sd1;
        tbl[1].exp = 4'd4; tbl[1].name = "neg_tie";
        for (int i = 0; i < DIM; i++) tbl[2].v[i] = 16'sh8000;
        tbl[2].exp = 4'd0; tbl[2].name = "all_min";
        for (int i = 0; i < DIM; i++) tbl[3].v[i] = 16'sd0;
        tbl[3].v[9] = 16'sh7FFF;
        tbl[3].exp = 4'd9; tbl[3].name = "max_last";
        for (int i = 0; i < DIM; i++) tbl[4].v[i] = 16'sd0;
        tbl[4].v[3] = -16'sd1;
        tbl[4].exp = 4'd0; tbl[4].name = "zero_tie";
        tbl[5].v = '{-16'sd5, -16'sd4, -16'sd3, -16'sd2, -16'sd1, -16'sd7, -16'sd8, -16'sd9, -16'sd10, -16'sd1};
        tbl[5].exp = 4'd4; tbl[5].name = "neg_ramp";
        for (int i = 0; i < DIM; i++) tbl[6].v[i] = 16'sd0;
        tbl[6].v[0] = 16'sh8000; tbl[6].v[5] = 16'sh7FFE; tbl[6].v[7] = 16'sh7FFF;
        tbl[6].exp = 4'd7; tbl[6].name = "signed_extremes";

        // Power-on reset.
        reset = 1'b1;
        #2;
        check("por_idx", idx, 0);
        check("por_done", done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        count_quiet(20, "idle_no_done");
        check("idle_idx", idx, 0);

        // Table vectors.
        for (int t = 0; t < 7; t++) begin
            launch(tbl[t].v);
            wait_check(tbl[t].exp, tbl[t].name);
        end

        // Snapshot: vec changes right after the start edge.
        for (int i = 0; i < DIM; i++) va[i] = 16'sd1;
        va[6] = 16'sd50;
        for (int i = 0; i < DIM; i++) vb[i] = 16'sd1;
        vb[1] = 16'sd90;
        launch(va);
        vec = vb;
        wait_check(4'd6, "snapshot");

        // Busy: second start at E3 is ignored.
        window(tbl[0].v, tbl[3].v, 3, nd, d1, d2, i1, i2);
        check("busy_ndone", nd, 1);
        check("busy_edge", d1, 10);
        check("busy_idx", i1, 2);

        // Back-to-back: start while done is high is accepted.
        window(tbl[0].v, tbl[3].v, 11, nd, d1, d2, i1, i2);
        check("b2b_ndone", nd, 2);
        check("b2b_edge1", d1, 10);
        check("b2b_idx1", i1, 2);
        check("b2b_edge2", d2, 21);
        check("b2b_idx2", i2, 9);

        // Abort: asynchronous reset mid-cycle during scan.
        launch(tbl[3].v);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("abort_idx", idx, 0);
        check("abort_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        count_quiet(20, "abort_no_done");
        launch(tbl[0].v);
        wait_check(4'd2, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
